// File: rtl/register_file_param_if.sv
// register_file_param_if: write, reserve and dual-read signal bundle for the
// register bank. The master drives requests; the slave (the bank) answers.
interface register_file_param_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
);
  localparam int AW = $clog2(DEPTH);

  logic               regWrite;
  logic [AW-1:0]      writeAddr;
  logic [WIDTH/8-1:0] byteEn;
  logic [WIDTH-1:0]   writeData;
  logic               reserve;
  logic [AW-1:0]      reserveAddr;
  logic               reserveOk;
  logic [AW-1:0]      readAddrA;
  logic [AW-1:0]      readAddrB;
  logic [WIDTH-1:0]   outA;
  logic [WIDTH-1:0]   outB;
  logic               busyA;
  logic               busyB;

  modport master (
    output regWrite, writeAddr, byteEn, writeData,
    output reserve, reserveAddr, readAddrA, readAddrB,
    input  reserveOk, outA, outB, busyA, busyB
  );

  modport slave (
    input  regWrite, writeAddr, byteEn, writeData,
    input  reserve, reserveAddr, readAddrA, readAddrB,
    output reserveOk, outA, outB, busyA, busyB
  );
endinterface

// File: rtl/register_file_param.sv
// register_file_param: DEPTH x WIDTH register bank with one byte-enabled
// write port, two combinational read ports that see a same-cycle write, and
// a per-register busy scoreboard used to reserve a register before writeback.
// With ZERO_REG set, register 0 is hard-wired to zero and never busy.
module register_file_param #(
  parameter int               WIDTH     = 16,
  parameter int               DEPTH     = 8,
  parameter int               ZERO_REG  = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input logic                  clk,
  input logic                  reset,
  register_file_param_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int NB = WIDTH / 8;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] busyNext;

  logic [AW-1:0]    wrAddr;
  logic [WIDTH-1:0] wrData;
  logic [NB-1:0]    wrByteEn;
  logic [AW-1:0]    rsvAddr;
  logic [WIDTH-1:0] byteMask;
  logic             writeLive;
  logic             writeStore;
  logic             reserveAccept;
  logic             reserveSet;

  assign wrAddr   = bus.writeAddr;
  assign wrData   = bus.writeData;
  assign wrByteEn = bus.byteEn;
  assign rsvAddr  = bus.reserveAddr;

  // Requests are ignored entirely while reset is held low.
  assign writeLive  = reset && bus.regWrite;
  assign writeStore = writeLive && !isZeroReg(wrAddr);

  function automatic logic isZeroReg(input logic [AW-1:0] addr);
    return (ZERO_REG != 0) && (addr == '0);
  endfunction

  // Stored value with the bytes of an in-progress write to the same address
  // substituted, so a consumer sees writeback data in the same cycle.
  function automatic logic [WIDTH-1:0] readPort(input logic [AW-1:0] addr);
    logic [WIDTH-1:0] value;
    value = mem[addr];
    if (writeLive && (wrAddr == addr)) begin
      value = (value & ~byteMask) | (wrData & byteMask);
    end
    if (isZeroReg(addr)) begin
      value = '0;
    end
    return value;
  endfunction

  // A register being written this cycle is already considered free.
  function automatic logic busyEff(input logic [AW-1:0] addr);
    return !isZeroReg(addr) && busy[addr] && !(writeLive && (wrAddr == addr));
  endfunction

  // Expand the per-byte enables into a bit mask over the data word.
  always_comb begin
    byteMask = '0;
    for (int i = 0; i < NB; i++) begin
      byteMask[8*i +: 8] = {8{wrByteEn[i]}};
    end
  end

  assign reserveAccept = reset && bus.reserve && !busyEff(rsvAddr);
  assign reserveSet    = reserveAccept && !isZeroReg(rsvAddr);

  assign bus.reserveOk = reserveAccept;
  assign bus.outA      = readPort(bus.readAddrA);
  assign bus.outB      = readPort(bus.readAddrB);
  assign bus.busyA     = busyEff(bus.readAddrA);
  assign bus.busyB     = busyEff(bus.readAddrB);

  // Next scoreboard: a write frees its register, a new reservation wins.
  always_comb begin
    busyNext = busy;
    if (writeStore) begin
      busyNext[wrAddr] = 1'b0;
    end
    if (reserveSet) begin
      busyNext[rsvAddr] = 1'b1;
    end
  end

  // Storage update: merge enabled bytes of the write into the addressed word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= RESET_VAL;
      end
    end else if (writeStore) begin
      mem[wrAddr] <= (mem[wrAddr] & ~byteMask) | (wrData & byteMask);
    end
  end

  // Scoreboard register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy <= '0;
    end else begin
      busy <= busyNext;
    end
  end
endmodule

// File: tb/tb_register_file_param.sv
// tb_register_file_param: checks a default bank (16x8, zero register) and a
// wide bank (32x16, no zero register, non-zero reset value) against a
// behavioural model of register contents and reservations.
module tb_register_file_param;
  localparam logic [31:0] RV1 = 32'h0BAD_F00D;

  logic clk;
  logic resetN;
  int   vectors;
  int   miscompares;

  logic [31:0] refMem0 [8];
  bit          refBusy0 [8];
  logic [31:0] refMem1 [16];
  bit          refBusy1 [16];

  register_file_param_if #(.WIDTH(16), .DEPTH(8))  bus0 ();
  register_file_param_if #(.WIDTH(32), .DEPTH(16)) bus1 ();

  register_file_param #(
    .WIDTH(16), .DEPTH(8), .ZERO_REG(1), .RESET_VAL(16'h0000)
  ) dut0 (
    .clk(clk), .reset(resetN), .bus(bus0)
  );

  register_file_param #(
    .WIDTH(32), .DEPTH(16), .ZERO_REG(0), .RESET_VAL(RV1)
  ) dut1 (
    .clk(clk), .reset(resetN), .bus(bus1)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] mergeBytes(input logic [31:0] old, input logic [31:0] data,
                                             input logic [3:0] be, input int nBytes);
    logic [31:0] res;
    res = old;
    for (int b = 0; b < nBytes; b++) begin
      if (be[b]) res[8*b +: 8] = data[8*b +: 8];
    end
    return res;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 8; i++) begin
      refMem0[i] = 32'h0;
      refBusy0[i] = 1'b0;
    end
    for (int i = 0; i < 16; i++) begin
      refMem1[i] = RV1;
      refBusy1[i] = 1'b0;
    end
  endtask

  function automatic logic [31:0] expOut0(input int a, input bit wr, input int wa,
                                          input logic [3:0] be, input logic [31:0] d);
    if (a == 0) return 32'h0;
    if (wr && wa == a) return mergeBytes(refMem0[a], d, be, 2);
    return refMem0[a];
  endfunction

  function automatic bit expBusy0(input int a, input bit wr, input int wa);
    if (a == 0) return 1'b0;
    return refBusy0[a] && !(wr && wa == a);
  endfunction

  function automatic logic [31:0] expOut1(input int a, input bit wr, input int wa,
                                          input logic [3:0] be, input logic [31:0] d);
    if (wr && wa == a) return mergeBytes(refMem1[a], d, be, 4);
    return refMem1[a];
  endfunction

  function automatic bit expBusy1(input int a, input bit wr, input int wa);
    return refBusy1[a] && !(wr && wa == a);
  endfunction

  // One cycle on the default bank: drive, check mid-cycle, clock, update model.
  task automatic applyStimulus(input string tag, input bit wr, input int wa,
                               input logic [3:0] be, input logic [31:0] d, input bit rsv,
                               input int ra, input int rdA, input int rdB);
    bit ok;
    bus0.regWrite    = wr;
    bus0.writeAddr   = 3'(wa);
    bus0.byteEn      = be[1:0];
    bus0.writeData   = d[15:0];
    bus0.reserve     = rsv;
    bus0.reserveAddr = 3'(ra);
    bus0.readAddrA   = 3'(rdA);
    bus0.readAddrB   = 3'(rdB);
    @(negedge clk);
    ok = rsv && !expBusy0(ra, wr, wa);
    checkOutput({tag, ".outA"}, 32'(bus0.outA), expOut0(rdA, wr, wa, be, {16'h0, d[15:0]}));
    checkOutput({tag, ".outB"}, 32'(bus0.outB), expOut0(rdB, wr, wa, be, {16'h0, d[15:0]}));
    checkOutput({tag, ".busyA"}, 32'(bus0.busyA), 32'(expBusy0(rdA, wr, wa)));
    checkOutput({tag, ".busyB"}, 32'(bus0.busyB), 32'(expBusy0(rdB, wr, wa)));
    checkOutput({tag, ".reserveOk"}, 32'(bus0.reserveOk), 32'(ok));
    @(posedge clk);
    if (wr && wa != 0) begin
      refMem0[wa] = mergeBytes(refMem0[wa], {16'h0, d[15:0]}, be, 2);
      refBusy0[wa] = 1'b0;
    end
    if (ok && ra != 0) refBusy0[ra] = 1'b1;
    #1;
    bus0.regWrite = 1'b0;
    bus0.reserve  = 1'b0;
  endtask

  // One cycle on the wide bank.
  task automatic applyStimulusWide(input string tag, input bit wr, input int wa,
                                   input logic [3:0] be, input logic [31:0] d, input bit rsv,
                                   input int ra, input int rdA, input int rdB);
    bit ok;
    bus1.regWrite    = wr;
    bus1.writeAddr   = 4'(wa);
    bus1.byteEn      = be;
    bus1.writeData   = d;
    bus1.reserve     = rsv;
    bus1.reserveAddr = 4'(ra);
    bus1.readAddrA   = 4'(rdA);
    bus1.readAddrB   = 4'(rdB);
    @(negedge clk);
    ok = rsv && !expBusy1(ra, wr, wa);
    checkOutput({tag, ".outA"}, bus1.outA, expOut1(rdA, wr, wa, be, d));
    checkOutput({tag, ".outB"}, bus1.outB, expOut1(rdB, wr, wa, be, d));
    checkOutput({tag, ".busyA"}, 32'(bus1.busyA), 32'(expBusy1(rdA, wr, wa)));
    checkOutput({tag, ".busyB"}, 32'(bus1.busyB), 32'(expBusy1(rdB, wr, wa)));
    checkOutput({tag, ".reserveOk"}, 32'(bus1.reserveOk), 32'(ok));
    @(posedge clk);
    if (wr) begin
      refMem1[wa] = mergeBytes(refMem1[wa], d, be, 4);
      refBusy1[wa] = 1'b0;
    end
    if (ok) refBusy1[ra] = 1'b1;
    #1;
    bus1.regWrite = 1'b0;
    bus1.reserve  = 1'b0;
  endtask

  // Directed and randomized sequence over both banks.
  initial begin
    vectors = 0;
    miscompares = 0;
    resetN = 1'b1;
    bus0.regWrite = 1'b0; bus0.writeAddr = '0; bus0.byteEn = '0; bus0.writeData = '0;
    bus0.reserve = 1'b0; bus0.reserveAddr = '0; bus0.readAddrA = '0; bus0.readAddrB = '0;
    bus1.regWrite = 1'b0; bus1.writeAddr = '0; bus1.byteEn = '0; bus1.writeData = '0;
    bus1.reserve = 1'b0; bus1.reserveAddr = '0; bus1.readAddrA = '0; bus1.readAddrB = '0;
    modelReset();

    // Reset with active requests: outputs show reset values, requests ignored.
    bus0.regWrite = 1'b1; bus0.writeAddr = 3'd3; bus0.byteEn = 2'b11; bus0.writeData = 16'h1234;
    bus0.reserve = 1'b1; bus0.reserveAddr = 3'd3; bus0.readAddrA = 3'd3; bus0.readAddrB = 3'd0;
    bus1.regWrite = 1'b1; bus1.writeAddr = 4'd0; bus1.byteEn = 4'hF; bus1.writeData = 32'h1111_2222;
    bus1.reserve = 1'b1; bus1.reserveAddr = 4'd0; bus1.readAddrA = 4'd0; bus1.readAddrB = 4'd9;
    #1 resetN = 1'b0;
    #1;
    checkOutput("rst.outA0", 32'(bus0.outA), 32'h0);
    checkOutput("rst.busyA0", 32'(bus0.busyA), 32'h0);
    checkOutput("rst.reserveOk0", 32'(bus0.reserveOk), 32'h0);
    checkOutput("rst.outA1", bus1.outA, RV1);
    checkOutput("rst.outB1", bus1.outB, RV1);
    checkOutput("rst.reserveOk1", 32'(bus1.reserveOk), 32'h0);
    @(posedge clk);
    #2;
    checkOutput("rstEdge.outA0", 32'(bus0.outA), 32'h0);
    checkOutput("rstEdge.outA1", bus1.outA, RV1);
    bus0.regWrite = 1'b0; bus0.reserve = 1'b0;
    bus1.regWrite = 1'b0; bus1.reserve = 1'b0;
    resetN = 1'b1;

    // Byte-enabled write with same-cycle bypass.
    applyStimulus("bw0", 1, 2, 4'b0011, 32'hAAAA, 0, 0, 2, 2);
    applyStimulus("bw1", 1, 2, 4'b0001, 32'h5511, 0, 0, 2, 2);
    applyStimulus("bw2", 0, 0, 4'b0000, 32'h0, 0, 0, 2, 2);
    checkOutput("bw.const", 32'(bus0.outA), 32'hAA11);

    // Register 0 is hard-wired: writes and reservations have no effect.
    applyStimulus("zr0", 1, 0, 4'b0011, 32'hFFFF, 1, 0, 0, 0);
    applyStimulus("zr1", 1, 0, 4'b0011, 32'hFFFF, 1, 0, 0, 0);
    checkOutput("zr.const", 32'(bus0.outA), 32'h0);

    // Scoreboard: reserve, refused re-reserve, write clears.
    applyStimulus("sb0", 0, 0, 4'b0000, 32'h0, 1, 5, 5, 5);
    checkOutput("sb.busyConst", 32'(bus0.busyB), 32'h1);
    applyStimulus("sb1", 0, 0, 4'b0000, 32'h0, 1, 5, 0, 5);
    applyStimulus("sb2", 1, 5, 4'b0011, 32'h1357, 0, 0, 0, 5);
    applyStimulus("sb3", 0, 0, 4'b0000, 32'h0, 0, 0, 5, 5);

    // Write and reserve on the same busy register in one cycle.
    applyStimulus("sim0", 0, 0, 4'b0000, 32'h0, 1, 4, 4, 4);
    applyStimulus("sim1", 1, 4, 4'b0011, 32'h0F0F, 1, 4, 4, 4);
    applyStimulus("sim2", 0, 0, 4'b0000, 32'h0, 0, 0, 4, 4);
    checkOutput("sim.busyConst", 32'(bus0.busyA), 32'h1);
    checkOutput("sim.dataConst", 32'(bus0.outA), 32'h0F0F);

    // A write with no bytes enabled still frees the register.
    applyStimulus("be0", 0, 0, 4'b0000, 32'h0, 1, 6, 6, 6);
    applyStimulus("be1", 1, 6, 4'b0000, 32'hBEEF, 0, 0, 6, 6);
    applyStimulus("be2", 0, 0, 4'b0000, 32'h0, 0, 0, 6, 6);

    // Randomized traffic on the default bank.
    for (int n = 0; n < 80; n++) begin
      applyStimulus($sformatf("rnd0_%0d", n), 1'($urandom_range(0, 1)),
                    int'($urandom_range(0, 7)), 4'($urandom_range(0, 3)),
                    32'($urandom_range(0, 16'hFFFF)), 1'($urandom_range(0, 1)),
                    int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                    int'($urandom_range(0, 7)));
    end

    // Reset in the middle of a write and a reservation.
    applyStimulus("mr0", 1, 3, 4'b0011, 32'h1234, 0, 0, 3, 3);
    applyStimulus("mr1", 0, 0, 4'b0000, 32'h0, 1, 3, 3, 3);
    bus0.regWrite = 1'b1; bus0.writeAddr = 3'd3; bus0.byteEn = 2'b11; bus0.writeData = 16'hCAFE;
    bus0.reserve = 1'b1; bus0.reserveAddr = 3'd2; bus0.readAddrA = 3'd3; bus0.readAddrB = 3'd2;
    bus1.readAddrA = 4'd7;
    #2 resetN = 1'b0;
    #1;
    modelReset();
    checkOutput("mid.outA", 32'(bus0.outA), 32'h0);
    checkOutput("mid.busyA", 32'(bus0.busyA), 32'h0);
    checkOutput("mid.reserveOk", 32'(bus0.reserveOk), 32'h0);
    checkOutput("mid.outA1", bus1.outA, RV1);
    @(posedge clk);
    #1;
    checkOutput("midEdge.outA", 32'(bus0.outA), 32'h0);
    bus0.regWrite = 1'b0; bus0.reserve = 1'b0;
    @(negedge clk);
    resetN = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus("post0", 0, 0, 4'b0000, 32'h0, 0, 0, 3, 2);

    // Wide bank: distinct value in every register, then read all back.
    for (int i = 0; i < 16; i++) begin
      applyStimulusWide($sformatf("sw.wr%0d", i), 1, i, 4'hF, 32'hA5A5_0000 + 32'(i) * 32'h0001_0101,
                        0, 0, i, (i + 1) % 16);
    end
    for (int i = 0; i < 16; i++) begin
      applyStimulusWide($sformatf("sw.rd%0d", i), 0, 0, 4'h0, 32'h0, 0, 0, i, 15 - i);
    end
    bus1.readAddrA = 4'd0;
    #1;
    checkOutput("sw.reg0", bus1.outA, 32'hA5A5_0000);

    // Randomized traffic on the wide bank.
    for (int n = 0; n < 60; n++) begin
      applyStimulusWide($sformatf("rnd1_%0d", n), 1'($urandom_range(0, 1)),
                        int'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                        32'($urandom()), 1'($urandom_range(0, 1)),
                        int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                        int'($urandom_range(0, 15)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/register_file_param.md
# register_file_param

Parametrised multi-register storage block: DEPTH registers of WIDTH bits, one byte-enabled write port, two combinational read ports with same-cycle write bypass, and a per-register busy scoreboard for reserve-before-write sequencing. It replaces hand-instantiated fixed 16-bit registers plus external decoders in the datapath register bank. It feeds operand reads in decode and accepts writeback results.

## Interface
- WIDTH, 16, data width in bits; must be a multiple of 8.
- DEPTH, 8, number of registers; must be a power of two and at least 2.
- AW, $clog2(DEPTH), address width; derived, never overridden.
- ZERO_REG, 1, when 1 register 0 reads as 0 and ignores writes and reservations.
- RESET_VAL, 0, WIDTH-bit value loaded into every register on reset.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- regWrite  in  1  write strobe.
- writeAddr  in  AW  register written when regWrite=1.
- byteEn  in  WIDTH/8  per-byte write enable; bit i covers bits [8i+7:8i].
- writeData  in  WIDTH  write data.
- reserve  in  1  request to mark reserveAddr busy.
- reserveAddr  in  AW  register to reserve.
- reserveOk  out  1  reservation accepted this cycle.
- readAddrA, readAddrB  in  AW  read addresses.
- outA, outB  out  WIDTH  read data.
- busyA, busyB  out  1  busy flag of the addressed register.

## Operation
- Storage: mem[0..DEPTH-1], each WIDTH bits. busy[0..DEPTH-1], one bit each.
- Write: on a rising edge with regWrite=1, each byte i of mem[writeAddr] with byteEn[i]=1 takes writeData byte i. Other bytes hold. When byteEn is all zero, no data changes, but the busy clear below still applies.
- Write clears busy[writeAddr] at the same edge.
- Read (combinational): outX = mem[readAddrX], with a bypass applied. When regWrite=1 and writeAddr==readAddrX, bytes with byteEn=1 come from writeData and the remaining bytes come from mem.
- Busy read (combinational): busyX = busy[readAddrX] && !(regWrite && writeAddr==readAddrX). A register being written this cycle reads as not busy.
- Reserve: reserveOk = reserve && !busyEff[reserveAddr], where busyEff is the bypassed busy value defined above. On a rising edge with reserveOk=1, busy[reserveAddr] is set.
- Write and reserve to the same address in the same cycle: the data is written, reserveOk=1, and busy ends up set. The new reservation wins over the clear.
- Reserve to an already-busy register that is not being written: reserveOk=0 and no state change. The requester retries; there is no internal queue.
- ZERO_REG=1, register 0:
  - reads return 0 and bypass does not apply;
  - busyX=0;
  - writes are discarded;
  - reserve to 0 gives reserveOk=1 and busy[0] is never set.
- Both read ports are fully independent and may address the same register.

## Timing
- Reset (reset=0, asynchronous, immediate): all mem = RESET_VAL and all busy = 0.
  - outA/outB then show RESET_VAL, or 0 for register 0 when ZERO_REG=1.
  - busyA/busyB = 0 and reserveOk = 0.
  - Inputs are ignored while reset=0.
- Reset asserted mid-operation discards any in-flight write or reservation of that cycle.
- Release is synchronous to the next clk edge; the first state update is the first rising edge after reset=1.
- Write latency: 0 cycles to the read ports via bypass; 1 edge to storage.
- Reserve latency: busy becomes visible on busyX starting the cycle after the accepting edge.
- Clear latency: 0 cycles on busyX and reserveOk via bypass; storage clears at the write edge.
- Every output is combinational from current state and inputs. There are no output registers.

## Test plan
- Reset: write 0x1234 to reg 3, then pulse reset=0 between edges → outA (addr 3) immediately equals RESET_VAL and busyA=0.
- Byte write: mem[2]=0xAAAA, then write 0x5511 with byteEn=2'b01 → during the write cycle outA (addr 2)=0xAA11 via bypass; next cycle it reads 0xAA11 from storage.
- Zero register (ZERO_REG=1): write 0xFFFF to reg 0, reserve reg 0 → outA=0, busyA=0, reserveOk=1 on every cycle.
- Scoreboard: reserve reg 5 (reserveOk=1) → busyB (addr 5)=1 next cycle; a second reserve of reg 5 gives reserveOk=0; a write to reg 5 gives busyB=0 in the same cycle.
- Simultaneous events: reg 4 busy; same cycle write 0x0F0F and reserve reg 4 → reserveOk=1, next cycle busy=1 and data=0x0F0F.
- Parameter sweep: WIDTH=32, DEPTH=16, ZERO_REG=0 → write distinct values to all 16 registers, read back on both ports, and confirm reg 0 is writable.
